pipe_stage_skid: RTL and testbench

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

---
 rtl/pipe_pkg.sv | 42 ++++
 rtl/sat_counter.sv | 26 ++
 rtl/pipe_stage_skid.sv | 115 +++++++++++
 tb/tb_pipe_stage_skid.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the EX/MEM pipeline stage: FSM state encodings,
// payload field layout and the default payload width.
// Purely declarative; no logic or latency of its own.
package pipe_pkg;

  // Stage occupancy states. The encoding equals the number of held entries.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_BUSY  = 2'b01,
    ST_FULL  = 2'b10
  } state_e;

  // EX/MEM payload field widths.
  localparam int W_CTRL   = 4;   // control flags
  localparam int W_SIZE   = 5;   // sizecontrol
  localparam int W_RT     = 32;  // Rt store data
  localparam int W_RD     = 5;   // destination register
  localparam int W_RESULT = 32;  // ALU result

  // EX/MEM payload bit offsets, packed LSB-first:
  // {result, rd, rt, sizecontrol, ctrl}.
  localparam int OFF_CTRL   = 0;
  localparam int OFF_SIZE   = OFF_CTRL + W_CTRL;
  localparam int OFF_RT     = OFF_SIZE + W_SIZE;
  localparam int OFF_RD     = OFF_RT + W_RT;
  localparam int OFF_RESULT = OFF_RD + W_RD;

  // Default payload width: the full EX/MEM bundle (78 bits).
  localparam int PIPE_PAYLOAD_W = OFF_RESULT + W_RESULT;

  // Number of held entries for a given state.
  function automatic logic [1:0] occ_of(state_e s);
    logic [1:0] occ;
    case (s)
      ST_BUSY: occ = 2'd1;
      ST_FULL: occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts cycles with i_inc high, sticks at all-ones.
// Latency: count reflects an increment one cycle after i_inc.
// Backpressure: none; cleared only by synchronous reset.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] count_q;

  // Increment on request until all-ones, then hold.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count_q <= '0;
    end else if (i_inc && (count_q != {CNT_W{1'b1}})) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign o_count = count_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// EX/MEM pipeline stage with skid register; optional stall counter (macro PIPE_STAGE_STALL_CNT_EN).
// Latency: 1 cycle from accept in EMPTY to o_valid; full throughput of 1 transfer/cycle.
// Backpressure: o_ready is registered and drops only when main and skid are both held.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int PAYLOAD_W = PIPE_PAYLOAD_W,
  parameter int CNT_W     = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [PAYLOAD_W-1:0] i_data,
  input  logic                 i_flush,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [PAYLOAD_W-1:0] o_data,
  output logic [1:0]           o_occupancy,
  output logic [CNT_W-1:0]     o_stall_cnt
);

  state_e               state_q, state_d;
  logic [PAYLOAD_W-1:0] main_q, main_d;
  logic [PAYLOAD_W-1:0] skid_q, skid_d;
  logic                 ready_q;
  logic                 accept;
  logic                 send;

  // o_ready comes straight from a flop, so downstream i_ready never reaches
  // the upstream handshake combinationally; the skid register absorbs the
  // one item that can arrive in the cycle the stall is first seen.
  assign o_ready     = ready_q;
  assign o_valid     = (state_q != ST_EMPTY);
  assign o_data      = main_q;
  assign o_occupancy = occ_of(state_q);

  assign accept = i_valid && ready_q;
  assign send   = o_valid && i_ready;

  // Next-state and payload selection; flush wins over every handshake and
  // only drops the valid state, leaving payload registers untouched.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (i_flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_d  = i_data;
            state_d = ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (accept && !send) begin
            skid_d  = i_data;
            state_d = ST_FULL;
          end else if (send && !accept) begin
            state_d = ST_EMPTY;
          end else if (send && accept) begin
            main_d  = i_data;
          end
        end
        ST_FULL: begin
          // o_ready is low here, so no accept can occur.
          if (send) begin
            main_d  = skid_q;
            state_d = ST_BUSY;
          end
        end
        default: begin
          // Unused encoding: recover to a clean empty stage.
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // State, payload and registered ready; reset overrides flush and handshakes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      ready_q <= (state_d != ST_FULL);
    end
  end

`ifdef PIPE_STAGE_STALL_CNT_EN
  logic stall;

  // A stall is a cycle where an item is on offer but downstream refuses it.
  assign stall = o_valid && !i_ready;

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_inc   (stall),
    .o_count (o_stall_cnt)
  );
`else
  assign o_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed vector table, stall-counter sequence,
// and randomized traffic against a queue-based reference model.
// Runs the DUT with CNT_W=4 so saturation is reachable quickly.
module tb_pipe_stage_skid;

  localparam int PW   = 78;
  localparam int CW   = 4;
  localparam int SMAX = (1 << CW) - 1;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_valid;
  logic          o_ready;
  logic [PW-1:0] i_data;
  logic          i_flush;
  logic          o_valid;
  logic          i_ready;
  logic [PW-1:0] o_data;
  logic [1:0]    o_occupancy;
  logic [CW-1:0] o_stall_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 i_clk = ~i_clk;

  pipe_stage_skid #(
    .PAYLOAD_W (PW),
    .CNT_W     (CW)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_data      (i_data),
    .i_flush     (i_flush),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_data      (o_data),
    .o_occupancy (o_occupancy),
    .o_stall_cnt (o_stall_cnt)
  );

  typedef struct {
    logic          rst;
    logic          valid;
    logic [PW-1:0] data;
    logic          flush;
    logic          ready;
    logic          exp_valid;
    logic          exp_ready;
    logic [PW-1:0] exp_data;
    logic [1:0]    exp_occ;
  } vec_t;

  vec_t tbl[$];

  // Reference model: the held items as an ordered queue.
  logic [PW-1:0] mq[$];
  logic [PW-1:0] m_shown;
  logic          m_ready;
  int            m_stall;

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rst, input logic valid, input logic [PW-1:0] data,
                              input logic flush, input logic ready, input logic ev,
                              input logic er, input logic [PW-1:0] ed, input logic [1:0] eo);
    vec_t v;
    v.rst = rst; v.valid = valid; v.data = data; v.flush = flush; v.ready = ready;
    v.exp_valid = ev; v.exp_ready = er; v.exp_data = ed; v.exp_occ = eo;
    return v;
  endfunction

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  function automatic int exp_stall(input int cnt);
`ifdef PIPE_STAGE_STALL_CNT_EN
    return cnt;
`else
    return 0 * cnt;
`endif
  endfunction

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_step();
    bit acc, snd;
    if (i_rst) begin
      mq.delete();
      m_shown = '0;
      m_ready = 1'b1;
      m_stall = 0;
    end else begin
      if (mq.size() > 0 && !i_ready && m_stall < SMAX) m_stall++;
      acc = i_valid && m_ready;
      snd = (mq.size() > 0) && i_ready;
      if (i_flush) begin
        mq.delete();
      end else begin
        if (snd) void'(mq.pop_front());
        if (acc) mq.push_back(i_data);
      end
      if (mq.size() > 0) m_shown = mq[0];
      m_ready = (mq.size() < 2);
    end
  endtask

  initial begin
    i_rst = 1'b1; i_valid = 1'b0; i_data = '0; i_flush = 1'b0; i_ready = 1'b0;

    // rst valid data flush ready | valid ready data occ
    tbl.push_back(mk(1, 0, 0,     0, 0, 0, 1, 0,     0));
    tbl.push_back(mk(0, 1, 1,     0, 1, 1, 1, 1,     1));
    for (int k = 2; k <= 8; k++)
      tbl.push_back(mk(0, 1, k,   0, 1, 1, 1, k,     1));
    tbl.push_back(mk(0, 0, 0,     0, 1, 0, 1, 8,     0));
    tbl.push_back(mk(0, 1, 'hA,   0, 0, 1, 1, 'hA,   1));
    tbl.push_back(mk(0, 1, 'hB,   0, 0, 1, 0, 'hA,   2));
    tbl.push_back(mk(0, 1, 'hD,   0, 0, 1, 0, 'hA,   2));
    tbl.push_back(mk(0, 0, 0,     0, 1, 1, 1, 'hB,   1));
    tbl.push_back(mk(0, 0, 0,     0, 1, 0, 1, 'hB,   0));
    tbl.push_back(mk(0, 1, 'h11,  0, 0, 1, 1, 'h11,  1));
    tbl.push_back(mk(0, 1, 'h12,  0, 0, 1, 0, 'h11,  2));
    tbl.push_back(mk(0, 1, 'hC,   1, 0, 0, 1, 'h11,  0));
    tbl.push_back(mk(0, 0, 0,     0, 1, 0, 1, 'h11,  0));
    tbl.push_back(mk(0, 1, 'h21,  0, 0, 1, 1, 'h21,  1));
    tbl.push_back(mk(0, 1, 'h22,  0, 0, 1, 0, 'h21,  2));
    tbl.push_back(mk(1, 1, 'h23,  1, 1, 0, 1, 0,     0));
    tbl.push_back(mk(0, 1, 'h31,  0, 1, 1, 1, 'h31,  1));
    tbl.push_back(mk(0, 1, 'h32,  1, 1, 0, 1, 'h31,  0));

    #1;
    foreach (tbl[i]) begin
      i_rst = tbl[i].rst; i_valid = tbl[i].valid; i_data = tbl[i].data;
      i_flush = tbl[i].flush; i_ready = tbl[i].ready;
      step();
      chk($sformatf("vec%0d_valid", i), PW'(o_valid),     PW'(tbl[i].exp_valid));
      chk($sformatf("vec%0d_ready", i), PW'(o_ready),     PW'(tbl[i].exp_ready));
      chk($sformatf("vec%0d_data",  i), o_data,           tbl[i].exp_data);
      chk($sformatf("vec%0d_occ",   i), PW'(o_occupancy), PW'(tbl[i].exp_occ));
    end

    // Stall counter: saturation, flush immunity, reset clear.
    i_rst = 1'b1; i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b0;
    step();
    chk("stall_reset", PW'(o_stall_cnt), 0);
    i_rst = 1'b0; i_valid = 1'b1; i_data = 'h55;
    step();
    i_valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (c == 4) chk("stall_after5", PW'(o_stall_cnt), PW'(exp_stall(5)));
    end
    chk("stall_sat", PW'(o_stall_cnt), PW'(exp_stall(15)));
    chk("stall_held_valid", PW'(o_valid), 1);
    chk("stall_held_data", o_data, 'h55);
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    chk("stall_after_flush", PW'(o_stall_cnt), PW'(exp_stall(15)));
    chk("stall_flush_valid", PW'(o_valid), 0);
    i_rst = 1'b1;
    step();
    chk("stall_after_rst", PW'(o_stall_cnt), 0);

    // Randomized traffic against the queue model.
    i_rst = 1'b1; i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b0;
    model_step();
    step();
    for (int n = 0; n < 3000; n++) begin
      i_rst   = ($urandom_range(0, 199) == 0);
      i_flush = ($urandom_range(0, 39) == 0);
      i_valid = ($urandom_range(0, 9) < 7);
      i_ready = ($urandom_range(0, 9) < 6);
      i_data  = {$urandom(), $urandom(), $urandom()};
      chk($sformatf("rnd%0d_valid", n), PW'(o_valid),     PW'(mq.size() > 0));
      chk($sformatf("rnd%0d_ready", n), PW'(o_ready),     PW'(m_ready));
      chk($sformatf("rnd%0d_data",  n), o_data,           m_shown);
      chk($sformatf("rnd%0d_occ",   n), PW'(o_occupancy), PW'(mq.size()));
      chk($sformatf("rnd%0d_stall", n), PW'(o_stall_cnt), PW'(exp_stall(m_stall)));
      model_step();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
